// File: rtl/spi_tx_sched.sv
// -----------------------------------------------------------------------------
// spi_tx_sched
//
// Transmit scheduler and command front-end for the SPInew SPI slave.
// Four local requesters are arbitrated round-robin; the winner's message type,
// byte count and 48-bit payload are registered onto the slave inputs and a
// one-cycle send_trigger is issued. The slave's busy line is tracked to detect
// completion; if the slave never starts or never finishes, it is recovered
// with a two-cycle reset pulse. Received 16-bit host commands are decoded, and
// a command whose upper byte equals LONG_OPCODE arms o_long_msg_coming for the
// following 48-bit host frame. No send is launched while the host owns the bus.
//
// Parameters
//   TIMEOUT_CYC  max cycles (trigger cycle included) until the send ends (>= 1)
//   START_CYC    max cycles (trigger cycle included) until busy rises (>= 1)
//   LONG_OPCODE  received_data[15:8] value announcing a long inbound frame
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_req[3:0]             level request per requester
//   i_req_type[11:0]       3-bit message type per requester
//   i_req_len[15:0]        4-bit byte count per requester (LONG type only)
//   i_req_data[191:0]      48-bit payload per requester
//   o_grant/o_done/o_err   one-cycle one-hot per-requester status pulses
//   o_send_trigger         one-cycle launch pulse to the slave
//   o_output_data          payload to the slave
//   o_spi_msg_type         message type to the slave
//   o_in_msg_byte_count    byte count to the slave
//   o_long_msg_coming      long inbound frame expected
//   o_spi_rst              active-high reset to the slave
//   i_busy                 slave is shifting a frame
//   i_received             slave received a frame (one-cycle pulse)
//   i_received_data[47:0]  received frame; only [15:0] is used
//   o_cmd_valid            one-cycle pulse, new command in o_cmd_data
//   o_cmd_data[15:0]       last decoded command
// -----------------------------------------------------------------------------
module spi_tx_sched #(
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF,
  parameter logic [15:0] START_CYC   = 16'd4,
  parameter logic [7:0]  LONG_OPCODE = 8'hA5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [3:0]   i_req,
  input  logic [11:0]  i_req_type,
  input  logic [15:0]  i_req_len,
  input  logic [191:0] i_req_data,
  output logic [3:0]   o_grant,
  output logic [3:0]   o_done,
  output logic [3:0]   o_err,
  output logic         o_send_trigger,
  output logic [47:0]  o_output_data,
  output logic [2:0]   o_spi_msg_type,
  output logic [3:0]   o_in_msg_byte_count,
  output logic         o_long_msg_coming,
  output logic         o_spi_rst,
  input  logic         i_busy,
  input  logic         i_received,
  input  logic [47:0]  i_received_data,
  output logic         o_cmd_valid,
  output logic [15:0]  o_cmd_data
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_END   = 2'd2,
    ST_RECOVER    = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_cur_idx;
  logic [15:0] r_cnt;
  logic        r_rec_first;

  logic [3:0]  r_grant;
  logic [3:0]  r_done;
  logic [3:0]  r_err;
  logic        r_send_trigger;
  logic [47:0] r_output_data;
  logic [2:0]  r_spi_msg_type;
  logic [3:0]  r_in_msg_byte_count;
  logic        r_long;
  logic        r_spi_rst;
  logic        r_cmd_valid;
  logic [15:0] r_cmd_data;

  logic [2:0]  w_type [4];
  logic [3:0]  w_len  [4];
  logic [47:0] w_data [4];
  logic        w_pick_found;
  logic [1:0]  w_pick_idx;
  logic        w_len_bad;
  logic        w_launch_ok;
  logic [15:0] w_cnt_inc;
  logic        w_rx_unused;

  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    f_onehot = 4'b0001 << idx;
  endfunction

  // Only the 16-bit command field of a received frame is consumed here.
  assign w_rx_unused = ^i_received_data[47:16];

  // Unpack the flat per-requester buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_type[i] = i_req_type[3*i +: 3];
      w_len[i]  = i_req_len[4*i +: 4];
      w_data[i] = i_req_data[48*i +: 48];
    end
  end

  // Round-robin pick: scan upward starting one past the last served requester.
  always_comb begin
    logic [1:0] v_scan;
    w_pick_found = 1'b0;
    w_pick_idx   = 2'd0;
    v_scan       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      v_scan = r_rr_ptr + 2'(k);
      if (!w_pick_found && i_req[v_scan]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = v_scan;
      end else begin
        w_pick_found = w_pick_found;
      end
    end
  end

  // Launch qualification; a LONG frame needs a byte count of 1..6.
  always_comb begin
    w_len_bad   = (w_type[w_pick_idx] == 3'b111) &&
                  ((w_len[w_pick_idx] == 4'd0) || (w_len[w_pick_idx] > 4'd6));
    w_launch_ok = w_pick_found && !i_busy && !i_received && !r_long;
    w_cnt_inc   = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);
  end

  // Scheduler FSM, command decoder and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state             <= ST_IDLE;
      r_rr_ptr            <= 2'd3;
      r_cur_idx           <= 2'd0;
      r_cnt               <= 16'd0;
      r_rec_first         <= 1'b0;
      r_grant             <= 4'd0;
      r_done              <= 4'd0;
      r_err               <= 4'd0;
      r_send_trigger      <= 1'b0;
      r_output_data       <= 48'h0;
      r_spi_msg_type      <= 3'b000;
      r_in_msg_byte_count <= 4'h0;
      r_long              <= 1'b0;
      r_spi_rst           <= 1'b0;
      r_cmd_valid         <= 1'b0;
      r_cmd_data          <= 16'h0;
    end else begin
      // Pulse outputs default low every cycle.
      r_grant        <= 4'd0;
      r_done         <= 4'd0;
      r_err          <= 4'd0;
      r_send_trigger <= 1'b0;
      r_cmd_valid    <= 1'b0;

      // Command decode; while the long flag is armed, the next reception is
      // the long host frame itself and only closes the window.
      if ((r_state != ST_RECOVER) && i_received) begin
        if (r_long) begin
          r_long <= 1'b0;
        end else begin
          r_cmd_data  <= i_received_data[15:0];
          r_cmd_valid <= 1'b1;
          if (i_received_data[15:8] == LONG_OPCODE) begin
            r_long <= 1'b1;
          end
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_launch_ok) begin
            // Rejected requesters still advance the pointer so they cannot
            // starve the others while they hold req.
            r_rr_ptr <= w_pick_idx;
            if (w_len_bad) begin
              r_err <= f_onehot(w_pick_idx);
            end else begin
              r_output_data       <= w_data[w_pick_idx];
              r_spi_msg_type      <= w_type[w_pick_idx];
              r_in_msg_byte_count <= w_len[w_pick_idx];
              r_send_trigger      <= 1'b1;
              r_grant             <= f_onehot(w_pick_idx);
              r_cur_idx           <= w_pick_idx;
              r_cnt               <= 16'd0;
              r_state             <= ST_WAIT_START;
            end
          end
        end

        // r_cnt is 0 in the trigger cycle, so comparing against N-1 allows
        // N cycles including the trigger cycle.
        ST_WAIT_START: begin
          if (i_busy) begin
            r_cnt   <= w_cnt_inc;
            r_state <= ST_WAIT_END;
          end else if (r_cnt >= (START_CYC - 16'd1)) begin
            r_state     <= ST_RECOVER;
            r_spi_rst   <= 1'b1;
            r_err       <= f_onehot(r_cur_idx);
            r_rec_first <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_WAIT_END: begin
          if (!i_busy) begin
            r_done  <= f_onehot(r_cur_idx);
            r_state <= ST_IDLE;
          end else if (r_cnt >= (TIMEOUT_CYC - 16'd1)) begin
            r_state     <= ST_RECOVER;
            r_spi_rst   <= 1'b1;
            r_err       <= f_onehot(r_cur_idx);
            r_rec_first <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        // Slave reset held for two cycles; the long-frame window is abandoned.
        ST_RECOVER: begin
          if (r_rec_first) begin
            r_rec_first <= 1'b0;
          end else begin
            r_spi_rst <= 1'b0;
            r_long    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_grant             = r_grant;
  assign o_done              = r_done;
  assign o_err               = r_err;
  assign o_send_trigger      = r_send_trigger;
  assign o_output_data       = r_output_data;
  assign o_spi_msg_type      = r_spi_msg_type;
  assign o_in_msg_byte_count = r_in_msg_byte_count;
  assign o_long_msg_coming   = r_long;
  assign o_spi_rst           = r_spi_rst;
  assign o_cmd_valid         = r_cmd_valid;
  assign o_cmd_data          = r_cmd_data;

endmodule

// File: tb/tb_spi_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_spi_tx_sched
//
// Directed bench for spi_tx_sched. Inputs change 1 time unit after each rising
// clock edge and outputs are sampled at that same point, so every check sees
// the register state produced by the preceding edge. The slave is emulated by
// driving busy/received directly. TIMEOUT_CYC is reduced to 100.
// -----------------------------------------------------------------------------
module tb_spi_tx_sched;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [11:0]  req_type;
  logic [15:0]  req_len;
  logic [191:0] req_data;
  logic [3:0]   grant;
  logic [3:0]   done;
  logic [3:0]   err;
  logic         send_trigger;
  logic [47:0]  output_data;
  logic [2:0]   spi_msg_type;
  logic [3:0]   in_msg_byte_count;
  logic         long_msg_coming;
  logic         spi_rst;
  logic         busy;
  logic         received;
  logic [47:0]  received_data;
  logic         cmd_valid;
  logic [15:0]  cmd_data;

  int n_assert = 0;
  int n_fail   = 0;

  spi_tx_sched #(
    .TIMEOUT_CYC(16'd100),
    .START_CYC  (16'd4),
    .LONG_OPCODE(8'hA5)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req              (req),
    .i_req_type         (req_type),
    .i_req_len          (req_len),
    .i_req_data         (req_data),
    .o_grant            (grant),
    .o_done             (done),
    .o_err              (err),
    .o_send_trigger     (send_trigger),
    .o_output_data      (output_data),
    .o_spi_msg_type     (spi_msg_type),
    .o_in_msg_byte_count(in_msg_byte_count),
    .o_long_msg_coming  (long_msg_coming),
    .o_spi_rst          (spi_rst),
    .i_busy             (busy),
    .i_received         (received),
    .i_received_data    (received_data),
    .o_cmd_valid        (cmd_valid),
    .o_cmd_data         (cmd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_trig"}, 64'(send_trigger), 64'd0);
    chk({tag, "_data"}, 64'(output_data), 64'd0);
    chk({tag, "_type"}, 64'(spi_msg_type), 64'd0);
    chk({tag, "_cnt"}, 64'(in_msg_byte_count), 64'd0);
    chk({tag, "_long"}, 64'(long_msg_coming), 64'd0);
    chk({tag, "_spirst"}, 64'(spi_rst), 64'd0);
    chk({tag, "_cmdv"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmdd"}, 64'(cmd_data), 64'd0);
  endtask

  // One complete frame: the launch must happen on the first edge, the slave
  // is busy for 'hold'+1 cycles and done must follow busy falling.
  task automatic frame(input string tag, input logic [3:0] exp_oh, input logic [47:0] exp_data,
                       input logic [2:0] exp_type, input logic [3:0] exp_len, input int hold);
    tick;
    chk({tag, "_grant"}, 64'(grant), 64'(exp_oh));
    chk({tag, "_trig"}, 64'(send_trigger), 64'd1);
    chk({tag, "_data"}, 64'(output_data), 64'(exp_data));
    chk({tag, "_type"}, 64'(spi_msg_type), 64'(exp_type));
    chk({tag, "_len"}, 64'(in_msg_byte_count), 64'(exp_len));
    busy = 1'b1;
    tick;
    chk({tag, "_trig_off"}, 64'(send_trigger), 64'd0);
    chk({tag, "_grant_off"}, 64'(grant), 64'd0);
    repeat (hold) tick;
    chk({tag, "_nodone"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, 64'(output_data), 64'(exp_data));
    busy = 1'b0;
    tick;
    chk({tag, "_done"}, 64'(done), 64'(exp_oh));
  endtask

  initial begin
    rst_n         = 1'b0;
    req           = 4'd0;
    req_type      = 12'd0;
    req_len       = 16'd0;
    req_data      = 192'd0;
    busy          = 1'b0;
    received      = 1'b0;
    received_data = 48'd0;

    // Reset values
    tick;
    tick;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick;
    chk("idle_grant", 64'(grant), 64'd0);

    // Round robin from reset: 0,1,2,3,0 with all requests held
    req_type = 12'b001_001_001_001;
    req_data[47:0]    = 48'hC0DE_0000_0000;
    req_data[95:48]   = 48'hC0DE_0000_0001;
    req_data[143:96]  = 48'hC0DE_0000_0002;
    req_data[191:144] = 48'hC0DE_0000_0003;
    req = 4'b1111;
    frame("rr0", 4'b0001, 48'hC0DE_0000_0000, 3'b001, 4'd0, 2);
    frame("rr1", 4'b0010, 48'hC0DE_0000_0001, 3'b001, 4'd0, 2);
    frame("rr2", 4'b0100, 48'hC0DE_0000_0002, 3'b001, 4'd0, 2);
    frame("rr3", 4'b1000, 48'hC0DE_0000_0003, 3'b001, 4'd0, 2);
    frame("rr4", 4'b0001, 48'hC0DE_0000_0000, 3'b001, 4'd0, 2);
    req = 4'd0;
    tick;
    chk("rr_end_grant", 64'(grant), 64'd0);
    chk("rr_end_trig", 64'(send_trigger), 64'd0);

    // Single requester, 16-bit frame (16 SCK edges)
    req_type[2:0]  = 3'b010;
    req_data[47:0] = 48'h0000_0000_BEEF;
    req = 4'b0001;
    frame("beef", 4'b0001, 48'h0000_0000_BEEF, 3'b010, 4'd0, 15);
    req = 4'd0;
    tick;
    chk("beef_idle_trig", 64'(send_trigger), 64'd0);
    chk("beef_idle_hold", 64'(output_data), 64'h0000_0000_BEEF);

    // LONG length check: 0 and 7 rejected, 6 accepted
    req_type[8:6] = 3'b111;
    req_len[11:8] = 4'd0;
    req = 4'b0100;
    tick;
    chk("len0_err", 64'(err), 64'b0100);
    chk("len0_trig", 64'(send_trigger), 64'd0);
    req = 4'd0;
    tick;
    chk("len0_err_off", 64'(err), 64'd0);
    req_len[11:8] = 4'd7;
    req = 4'b0100;
    tick;
    chk("len7_err", 64'(err), 64'b0100);
    chk("len7_trig", 64'(send_trigger), 64'd0);
    chk("len7_grant", 64'(grant), 64'd0);
    req = 4'd0;
    tick;
    chk("len7_err_off", 64'(err), 64'd0);
    req_len[11:8]     = 4'd6;
    req_data[143:96]  = 48'h0102_0304_0506;
    req = 4'b0100;
    frame("len6", 4'b0100, 48'h0102_0304_0506, 3'b111, 4'd6, 4);
    req = 4'd0;
    tick;

    // Plain command
    received      = 1'b1;
    received_data = 48'h0000_0000_1234;
    tick;
    received = 1'b0;
    chk("cmd_valid", 64'(cmd_valid), 64'd1);
    chk("cmd_data", 64'(cmd_data), 64'h1234);
    chk("cmd_long", 64'(long_msg_coming), 64'd0);
    tick;
    chk("cmd_valid_off", 64'(cmd_valid), 64'd0);

    // Long-frame announcement blocks the pending req[1]
    req           = 4'b0010;
    received      = 1'b1;
    received_data = 48'h1234_5678_A512;
    tick;
    received = 1'b0;
    chk("lc_valid", 64'(cmd_valid), 64'd1);
    chk("lc_data", 64'(cmd_data), 64'hA512);
    chk("lc_long", 64'(long_msg_coming), 64'd1);
    chk("lc_grant0", 64'(grant), 64'd0);
    tick;
    chk("lc_valid_off", 64'(cmd_valid), 64'd0);
    chk("lc_grant1", 64'(grant), 64'd0);
    tick;
    chk("lc_grant2", 64'(grant), 64'd0);
    chk("lc_long_hold", 64'(long_msg_coming), 64'd1);
    received      = 1'b1;
    received_data = 48'hFFFF_FFFF_A5A5;
    tick;
    received = 1'b0;
    chk("lc_end_long", 64'(long_msg_coming), 64'd0);
    chk("lc_end_valid", 64'(cmd_valid), 64'd0);
    chk("lc_end_data", 64'(cmd_data), 64'hA512);
    chk("lc_end_grant", 64'(grant), 64'd0);
    frame("lc_req1", 4'b0010, 48'hC0DE_0000_0001, 3'b001, 4'd0, 3);
    req = 4'd0;
    tick;

    // Slave never raises busy: abort after START_CYC cycles
    req = 4'b1000;
    tick;
    chk("st_grant", 64'(grant), 64'b1000);
    repeat (3) tick;
    chk("st_no_rst", 64'(spi_rst), 64'd0);
    tick;
    chk("st_rst1", 64'(spi_rst), 64'd1);
    chk("st_err", 64'(err), 64'b1000);
    req = 4'd0;
    tick;
    chk("st_rst2", 64'(spi_rst), 64'd1);
    chk("st_err_off", 64'(err), 64'd0);
    tick;
    chk("st_rst_off", 64'(spi_rst), 64'd0);

    // SCK stalls mid-send: abort after TIMEOUT_CYC=100 cycles; a long-frame
    // announcement received during the send is abandoned by recovery
    req = 4'b0001;
    tick;
    chk("to_grant", 64'(grant), 64'b0001);
    busy = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      if (i == 2) begin
        received      = 1'b1;
        received_data = 48'h0000_0000_A500;
      end
      tick;
      received = 1'b0;
      if (i == 2) begin
        chk("to_cmd_valid", 64'(cmd_valid), 64'd1);
        chk("to_long", 64'(long_msg_coming), 64'd1);
      end
    end
    chk("to_no_rst", 64'(spi_rst), 64'd0);
    chk("to_no_done", 64'(done), 64'd0);
    tick;
    chk("to_rst1", 64'(spi_rst), 64'd1);
    chk("to_err", 64'(err), 64'b0001);
    busy = 1'b0;
    req  = 4'd0;
    tick;
    chk("to_rst2", 64'(spi_rst), 64'd1);
    chk("to_err_off", 64'(err), 64'd0);
    chk("to_long_hold", 64'(long_msg_coming), 64'd1);
    tick;
    chk("to_rst_off", 64'(spi_rst), 64'd0);
    chk("to_long_clr", 64'(long_msg_coming), 64'd0);

    // Asynchronous reset during WAIT_END
    req = 4'b0010;
    tick;
    chk("ar_grant", 64'(grant), 64'b0010);
    busy = 1'b1;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("ar");
    busy = 1'b0;
    req  = 4'b1111;
    #1;
    rst_n = 1'b1;
    tick;
    chk("ar_prio_grant", 64'(grant), 64'b0001);
    chk("ar_prio_trig", 64'(send_trigger), 64'd1);
    req = 4'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_tx_sched.md
# spi_tx_sched

Transmit scheduler and command front-end for the `SPInew` SPI slave. Four local requesters compete to send a response frame to the SPI master; this block arbitrates them round-robin and drives the slave's `send_trigger`, `output_data`, `SPI_MSG_TYPE` and `InMsgByteCount` inputs. It tracks `busy` to detect completion, and recovers a stalled slave by pulsing its reset. It also decodes received 16-bit commands, arms `LongMsgComing` for a following 48-bit host frame, and never launches a send while the host owns the bus.

## Interface
- `TIMEOUT_CYC`, 16'hFFFF: max CLK cycles from trigger to end of send before abort.
- `START_CYC`, 4: max CLK cycles from trigger until `busy`=1 before abort.
- `LONG_OPCODE`, 8'hA5: value of `received_data[15:8]` that announces a long inbound frame.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `req`  in  4  level request per requester; held until `done`/`err` for that requester.
- `req_type`  in  12  3-bit message type per requester, requester i at [3i+2:3i].
- `req_len`  in  16  4-bit byte count per requester, requester i at [4i+3:4i]; only used for type 3'b111.
- `req_data`  in  192  48-bit payload per requester, requester i at [48i+47:48i].
- `grant`  out  4  one-cycle one-hot pulse when requester's frame is launched.
- `done`  out  4  one-cycle pulse when that frame has been fully shifted out.
- `err`  out  4  one-cycle pulse on rejection or abort.
- `send_trigger`  out  1  to slave; one-cycle pulse.
- `output_data`  out  48  to slave; payload of the granted requester.
- `SPI_MSG_TYPE`  out  3  to slave.
- `InMsgByteCount`  out  4  to slave.
- `LongMsgComing`  out  1  to slave.
- `spi_rst`  out  1  to slave's active-high `RST`.
- `busy`  in  1  from slave.
- `received`  in  1  from slave; one-cycle pulse.
- `received_data`  in  48  from slave; only [15:0] is used.
- `cmd_valid`  out  1  one-cycle pulse; a 16-bit command is available.
- `cmd_data`  out  16  last command; held until the next `cmd_valid`.

## Operation
- States: IDLE, WAIT_START, WAIT_END, RECOVER.
- **IDLE.** A launch happens when `req`≠0, `busy`=0, `received`=0 and `LongMsgComing`=0.
  - Round-robin pick: scan upward from `rr_ptr`+1 mod 4 and select the first set bit.
  - Register the winner's type, length and data onto the slave outputs.
  - Assert `send_trigger`=1 and `grant[i]`=1 for the next cycle; set `rr_ptr`=i; go to WAIT_START.
- **Length check (LONG only).** For type 3'b111 with `req_len`=0 or `req_len`>6: no launch.
  - Pulse `err[i]`, set `rr_ptr`=i, stay in IDLE.
  - All other types are passed through unchanged; the slave treats undefined types as 2 bytes.
- **WAIT_START.** Trigger is already deasserted.
  - `busy`=1 -> WAIT_END.
  - `START_CYC` cycles elapse without `busy`=1 -> RECOVER.
- **WAIT_END.** `busy`=0 -> pulse `done[i]`, go to IDLE.
  - Total cycles since trigger reach `TIMEOUT_CYC` -> RECOVER.
- **RECOVER.** Drive `spi_rst`=1 for 2 cycles; pulse `err[i]` on the first of them.
  - Clear `LongMsgComing`, then go to IDLE.
- **Hold rule.** `output_data`, `SPI_MSG_TYPE` and `InMsgByteCount` stay stable from trigger until `done`/`err`. In IDLE they hold their last value.
- **Command decode** runs in every state except RECOVER.
  - On `received`=1 with `LongMsgComing`=0: `cmd_data`<=`received_data[15:0]`, `cmd_valid` pulses next cycle. If `received_data[15:8]`==`LONG_OPCODE`, also set `LongMsgComing`=1.
  - On `received`=1 with `LongMsgComing`=1: this marks long-frame completion. Clear `LongMsgComing`; no `cmd_valid`.
- **Timeout counter.** 16-bit, cleared at trigger, saturates at all-ones.

## Timing
- Reset values:
  - `grant`, `done`, `err`, `send_trigger`, `spi_rst`, `LongMsgComing`, `cmd_valid` = 0.
  - `output_data`=48'h0, `SPI_MSG_TYPE`=3'b000, `InMsgByteCount`=4'h0, `cmd_data`=16'h0.
  - State IDLE; `rr_ptr`=3, so requester 0 has first priority.
- Launch latency: `req` seen in IDLE at cycle T -> `send_trigger`/`grant` high in cycle T+1 -> slave `busy` expected at T+2.
- Completion: `done` is registered, one cycle after `busy` is sampled low.
- `received` and a launch condition in the same cycle: the receive is processed and the launch is deferred one cycle.
- A requester that drops `req` after `grant` still receives `done`/`err`.
- `RST_N` asserted mid-frame: immediately resets to reset values; the slave is not reset by this block.

## Test plan
- `req`=4'b0001, type 3'b010, data 48'h0000_0000_BEEF -> trigger at T+1 with `output_data`=48'h..BEEF, `SPI_MSG_TYPE`=3'b010; after 16 SCK rising edges `busy` falls and `done[0]` pulses.
- `req`=4'b1111 held, all types 3'b001 -> grant order 0,1,2,3,0; exactly one `grant` per frame.
- Requester 2 with type 3'b111 and `req_len`=7 -> `err[2]` pulse, no trigger. With `req_len`=6 -> trigger and `InMsgByteCount`=6.
- Host sends 16'hA512 -> `cmd_valid` with `cmd_data`=16'hA512 and `LongMsgComing`=1; pending `req[1]` is not granted. Next `received` -> `LongMsgComing`=0, no `cmd_valid`, then `grant[1]`.
- SCK stopped mid-send with `TIMEOUT_CYC`=100 -> `spi_rst` high 2 cycles, `err[i]` pulse, back to IDLE.
- `RST_N` low during WAIT_END -> all outputs at reset values in the same cycle; after release, requester 0 has priority.
